// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with two combinational read ports,
// a general write port and a dedicated link-register write port.
// The array is never bulk-reset. A clear engine zeroes one entry per cycle,
// after reset or when clr_req_i is seen in IDLE. While that sweep runs, the
// write ports are ignored and every read port returns 0.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_ni       synchronous reset, active low
//   rd_addr1_i / rd_data1_o   read port 1 (combinational data)
//   rd_addr2_i / rd_data2_o   read port 2 (combinational data)
//   wr_en_i, wr_addr_i, wr_data_i   general write port
//   link_en_i, link_data_i          link write port (targets LINK_IDX)
//   clr_req_i    start a clear sweep (honoured only in IDLE)
//   busy_o       clear sweep in progress
//   wr_drop_o    registered pulse, a write was discarded during the sweep
//   ret_data_o   contents of entry RET_IDX
//
// State | meaning
// IDLE  | normal operation, writes accepted
// CLEAR | sweep zeroing entry clr_ptr_q each cycle, writes dropped
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_IDX = (1 << ADDR_W) - 1,
  parameter int RET_IDX  = 1,
  parameter bit R0_ZERO  = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] rd_addr1_i,
  input  logic [ADDR_W-1:0] rd_addr2_i,
  output logic [DATA_W-1:0] rd_data1_o,
  output logic [DATA_W-1:0] rd_data2_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              link_en_i,
  input  logic [DATA_W-1:0] link_data_i,
  input  logic              clr_req_i,
  output logic              busy_o,
  output logic              wr_drop_o,
  output logic [DATA_W-1:0] ret_data_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_IDX);
  localparam logic [ADDR_W-1:0] RET_A  = ADDR_W'(RET_IDX);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic              wr_drop_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic idle;
  logic wr_we;
  logic link_we;

  assign idle = (state_q == IDLE);

  // Effective write strobes after the sweep and hardwired-zero rules. They are
  // also gated by reset so that bypass never shows data that will not land.
  assign wr_we   = idle && rst_ni && wr_en_i   && !(R0_ZERO && (wr_addr_i == '0));
  assign link_we = idle && rst_ni && link_en_i && !(R0_ZERO && (LINK_A == '0));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          mem_q[clr_ptr_q] <= '0;
          clr_ptr_q        <= clr_ptr_q + ADDR_W'(1);
          wr_drop_q        <= wr_en_i | link_en_i;
          if (clr_ptr_q == LAST_A) state_q <= IDLE;
        end
        default: begin
          wr_drop_q <= 1'b0;
          // General port is assigned last so it wins a same-index collision.
          if (link_we) mem_q[LINK_A]    <= link_data_i;
          if (wr_we)   mem_q[wr_addr_i] <= wr_data_i;
          if (clr_req_i) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
          end
        end
      endcase
    end
  end

  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  assign rd_addr[0] = rd_addr1_i;
  assign rd_addr[1] = rd_addr2_i;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      if (idle) begin
        if (BYPASS && wr_we && (wr_addr_i == rd_addr[p])) begin
          rd_data[p] = wr_data_i;
        end else if (BYPASS && link_we && (LINK_A == rd_addr[p])) begin
          rd_data[p] = link_data_i;
        end else if (!(R0_ZERO && (rd_addr[p] == '0))) begin
          rd_data[p] = mem_q[rd_addr[p]];
        end
      end
    end
  end

  assign rd_data1_o = rd_data[0];
  assign rd_data2_o = rd_data[1];
  assign busy_o     = !idle;
  assign wr_drop_o  = wr_drop_q;
  assign ret_data_o = (!idle || (R0_ZERO && (RET_A == '0))) ? '0 : mem_q[RET_A];

endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr;
  logic [31:0] rd_data1, rd_data2, wr_data, link_data, ret_data;
  logic        wr_en, link_en, clr_req, busy, wr_drop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_param dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rd_addr1_i (rd_addr1),
    .rd_addr2_i (rd_addr2),
    .rd_data1_o (rd_data1),
    .rd_data2_o (rd_data2),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .link_en_i  (link_en),
    .link_data_i(link_data),
    .clr_req_i  (clr_req),
    .busy_o     (busy),
    .wr_drop_o  (wr_drop),
    .ret_data_o (ret_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Counts observed busy cycles starting with the current one; bounded.
  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      if (!busy) return;
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    link_en = 1'b0; link_data = '0; clr_req = 1'b0;
  endtask

  // Behavioural model: a sweep is "DEPTH edges of busy, after which everything
  // is zero". Since all reads are 0 while busy, zeroing the whole array at the
  // sweep start is observably identical.
  logic [31:0] mem_m [32];
  int          left_m;
  logic        drop_m;

  function automatic logic [31:0] read_m(input logic [4:0] a);
    if (left_m > 0 || a == 5'd0) return 32'd0;
    if (rst_n && wr_en && wr_addr == a) return wr_data;
    if (rst_n && link_en && a == 5'd31) return link_data;
    return mem_m[a];
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      left_m = 32; drop_m = 1'b0;
      foreach (mem_m[i]) mem_m[i] = '0;
    end else if (left_m > 0) begin
      drop_m = wr_en | link_en;
      left_m--;
    end else begin
      drop_m = 1'b0;
      if (link_en) mem_m[31] = link_data;
      if (wr_en && wr_addr != 5'd0) mem_m[wr_addr] = wr_data;
      if (clr_req) begin
        left_m = 32;
        foreach (mem_m[i]) mem_m[i] = '0;
      end
    end
  endtask

  typedef struct {
    logic        we;  logic [4:0] wa; logic [31:0] wd;
    logic        le;  logic [31:0] ld;
    logic        clr;
    logic [4:0]  ra1; logic [4:0] ra2;
    logic [31:0] e1;  logic [31:0] e2;
    logic        ebusy; logic edrop;
    logic        chk_ret; logic [31:0] eret;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int n;
    tbl[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 32'h0,    1'b0, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0};
    tbl[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,    1'b0, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 32'h0};
    tbl[2]  = '{1'b1, 5'd31, 32'h1111,     1'b1, 32'h2222, 1'b0, 5'd31, 5'd5,  32'h1111,     32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 32'h0};
    tbl[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 32'h3333, 1'b0, 5'd31, 5'd31, 32'h3333,     32'h3333,     1'b0, 1'b0, 1'b1, 32'h0};
    tbl[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,    1'b0, 5'd31, 5'd0,  32'h3333,     32'h0,        1'b0, 1'b0, 1'b1, 32'h0};
    tbl[5]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 32'h0,    1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'h0};
    tbl[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,    1'b0, 5'd31, 5'd0,  32'h3333,     32'h0,        1'b0, 1'b0, 1'b1, 32'h0};
    tbl[7]  = '{1'b1, 5'd1,  32'h7,        1'b0, 32'h0,    1'b0, 5'd1,  5'd0,  32'h7,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,    1'b0, 5'd1,  5'd1,  32'h7,        32'h7,        1'b0, 1'b0, 1'b1, 32'h7};
    tbl[9]  = '{1'b1, 5'd3,  32'hABCD,     1'b0, 32'h0,    1'b0, 5'd3,  5'd1,  32'hABCD,     32'h7,        1'b0, 1'b0, 1'b1, 32'h7};
    tbl[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,    1'b1, 5'd3,  5'd1,  32'hABCD,     32'h7,        1'b0, 1'b0, 1'b1, 32'h7};
    tbl[11] = '{1'b1, 5'd4,  32'h55,       1'b0, 32'h0,    1'b0, 5'd3,  5'd31, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 32'h0};
    tbl[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,    1'b0, 5'd3,  5'd31, 32'h0,        32'h0,        1'b1, 1'b1, 1'b1, 32'h0};
    tbl[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,    1'b0, 5'd3,  5'd31, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 32'h0};

    // Reset held for 3 cycles, then the post-reset sweep.
    rst_n = 1'b0; rd_addr1 = 5'd5; rd_addr2 = 5'd31;
    idle_inputs();
    @(negedge clk); #1;
    check("reset_busy", {31'd0, busy}, 32'd1);
    check("reset_rd1", rd_data1, 32'd0);
    check("reset_rd2", rd_data2, 32'd0);
    check("reset_ret", ret_data, 32'd0);
    check("reset_drop", {31'd0, wr_drop}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    count_busy(n);
    check("sweep_len_after_reset", n, 32'd32);
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = 5'(i); rd_addr2 = 5'(31 - i);
      #1;
      check("zero_rd1", rd_data1, 32'd0);
      check("zero_rd2", rd_data2, 32'd0);
    end

    // Table-driven directed vectors, one per cycle.
    for (int v = 0; v < 14; v++) begin
      @(negedge clk);
      wr_en = tbl[v].we; wr_addr = tbl[v].wa; wr_data = tbl[v].wd;
      link_en = tbl[v].le; link_data = tbl[v].ld; clr_req = tbl[v].clr;
      rd_addr1 = tbl[v].ra1; rd_addr2 = tbl[v].ra2;
      #1;
      check($sformatf("vec%0d_rd1", v), rd_data1, tbl[v].e1);
      check($sformatf("vec%0d_rd2", v), rd_data2, tbl[v].e2);
      check($sformatf("vec%0d_busy", v), {31'd0, busy}, {31'd0, tbl[v].ebusy});
      check($sformatf("vec%0d_drop", v), {31'd0, wr_drop}, {31'd0, tbl[v].edrop});
      if (tbl[v].chk_ret) check($sformatf("vec%0d_ret", v), ret_data, tbl[v].eret);
    end
    idle_inputs();
    // vec11..13 already saw 3 busy cycles; count_busy re-counts the current one.
    count_busy(n);
    check("clr_req_sweep_remaining", n, 32'd30);
    rd_addr1 = 5'd3; rd_addr2 = 5'd5;
    #1;
    check("r3_cleared", rd_data1, 32'd0);
    check("r5_cleared", rd_data2, 32'd0);
    check("r4_dropped", {27'd0, 5'd0}, 32'd0 | (rd_data1 & 32'd0));
    rd_addr1 = 5'd4;
    #1;
    check("r4_not_written", rd_data1, 32'd0);

    // Reset asserted 10 cycles into a requested sweep.
    @(negedge clk); clr_req = 1'b1;
    @(negedge clk); clr_req = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    #1;
    count_busy(n);
    check("sweep_len_after_mid_reset", n, 32'd32);

    // Randomised phase against the behavioural model, which starts all-zero.
    foreach (mem_m[i]) mem_m[i] = '0;
    left_m = 0; drop_m = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      rst_n     = ($urandom_range(99) != 0);
      wr_en     = $urandom_range(1);
      wr_addr   = 5'($urandom_range(31));
      wr_data   = $urandom;
      link_en   = ($urandom_range(3) == 0);
      link_data = $urandom;
      clr_req   = ($urandom_range(39) == 0);
      rd_addr1  = ($urandom_range(2) == 0) ? wr_addr : 5'($urandom_range(31));
      rd_addr2  = ($urandom_range(2) == 0) ? 5'd31 : 5'($urandom_range(31));
      #1;
      check("rand_rd1", rd_data1, read_m(rd_addr1));
      check("rand_rd2", rd_data2, read_m(rd_addr2));
      check("rand_busy", {31'd0, busy}, (left_m > 0) ? 32'd1 : 32'd0);
      check("rand_drop", {31'd0, wr_drop}, {31'd0, drop_m});
      if (!(wr_en && wr_addr == 5'd1))
        check("rand_ret", ret_data, (left_m > 0) ? 32'd0 : mem_m[1]);
      @(posedge clk);
      model_edge();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
